// File: rtl/i2s_pkg.sv
// Shared constants and state type for the MSB-justified I2S capture path.
package i2s_pkg;

  localparam int FRAME_BITS      = 256;
  localparam int SLOT_BITS       = 32;
  localparam int HALF_FRAME_BITS = FRAME_BITS / 2;
  localparam int BIT_W           = $clog2(FRAME_BITS);

  typedef enum logic {RX_HUNT, RX_RECEIVE} i2s_rx_state_t;

  // lrclk is high for the first half of the frame and low for the second half
  function automatic logic expected_lrclk(input logic [BIT_W-1:0] bit_idx);
    return 32'(bit_idx) < HALF_FRAME_BITS;
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchroniser with a registered rising-edge pulse (one clk wide).
module sync_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], async_in};
      prev_reg <= sync_reg[1];
      rise_reg <= sync_reg[1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/i2s_msb_receiver.sv
// MSB-justified I2S frame capture into a circular bit-serial RAM buffer.
// Optional error counter port err_count_o is built when I2S_RX_ERR_CNT_EN is defined.
module i2s_msb_receiver
  import i2s_pkg::*;
#(
  parameter int CIRC_BUF_BITS = 3,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic                       clk_x4_i,
  input  logic                       rst_ni,
  input  logic                       i2s_bclk_i,
  input  logic                       i2s_lrclk_i,
  input  logic                       i2s_data_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
  output logic                       ram_write_data_o,
  output logic                       ram_wr_en_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic                       frame_strobe_o,
  output logic                       i2s_locked_o
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [7:0]                 err_count_o
`endif
);

  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(FRAME_BITS - 1);
  localparam logic [3:0]       LOCK_CNT     = 4'(LOCK_FRAMES);
  localparam logic [3:0]       LOCK_CNT_M1  = 4'(LOCK_FRAMES - 1);

  logic bclk_rise;

  sync_edge_detector u_bclk_sync (
    .clk      (clk_x4_i),
    .rst_n    (rst_ni),
    .async_in (i2s_bclk_i),
    .rise     (bclk_rise)
  );

  // Third stage keeps lrclk/data aligned with the registered bclk edge pulse
  logic [1:0] raw_in;
  logic [1:0] aligned;
  assign raw_in = {i2s_data_i, i2s_lrclk_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [2:0] chain_reg;
      always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) chain_reg <= 3'b000;
        else         chain_reg <= {chain_reg[1:0], raw_in[gi]};
      end
      assign aligned[gi] = chain_reg[2];
    end
  endgenerate

  logic lrclk_smp;
  logic data_smp;
  assign lrclk_smp = aligned[0];
  assign data_smp  = aligned[1];

  i2s_rx_state_t              state_reg;
  logic [BIT_W-1:0]           bit_cnt_reg;
  logic [CIRC_BUF_BITS-1:0]   wr_frame_reg;
  logic [3:0]                 good_cnt_reg;
  logic                       prev_lrclk_reg;
  logic [CIRC_BUF_BITS+7:0]   addr_reg;
  logic                       data_reg;
  logic                       wr_en_reg;
  logic [CIRC_BUF_BITS-1:0]   last_good_reg;
  logic                       strobe_reg;
  logic                       locked_reg;
  logic [7:0]                 err_cnt_reg;

  always_ff @(posedge clk_x4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= RX_HUNT;
      bit_cnt_reg    <= '0;
      wr_frame_reg   <= '0;
      good_cnt_reg   <= '0;
      prev_lrclk_reg <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= 1'b0;
      wr_en_reg      <= 1'b0;
      last_good_reg  <= '0;
      strobe_reg     <= 1'b0;
      locked_reg     <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      wr_en_reg  <= 1'b0;
      strobe_reg <= 1'b0;
      if (bclk_rise) begin
        prev_lrclk_reg <= lrclk_smp;
        case (state_reg)
          RX_HUNT: begin
            if (lrclk_smp && !prev_lrclk_reg) begin
              addr_reg    <= {wr_frame_reg, BIT_W'(0)};
              data_reg    <= data_smp;
              wr_en_reg   <= 1'b1;
              bit_cnt_reg <= BIT_W'(1);
              state_reg   <= RX_RECEIVE;
            end
          end
          RX_RECEIVE: begin
            if (lrclk_smp == expected_lrclk(bit_cnt_reg)) begin
              addr_reg    <= {wr_frame_reg, bit_cnt_reg};
              data_reg    <= data_smp;
              wr_en_reg   <= 1'b1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == LAST_BIT) begin
                last_good_reg <= wr_frame_reg;
                strobe_reg    <= 1'b1;
                wr_frame_reg  <= wr_frame_reg + 1'b1;
                if (good_cnt_reg != LOCK_CNT) begin
                  good_cnt_reg <= good_cnt_reg + 1'b1;
                  if (good_cnt_reg == LOCK_CNT_M1) locked_reg <= 1'b1;
                end
              end
            end else begin
              // Partial frame stays in its slot and is overwritten by the next attempt
              state_reg    <= RX_HUNT;
              locked_reg   <= 1'b0;
              good_cnt_reg <= '0;
              if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= RX_HUNT;
        endcase
      end
    end
  end

  assign ram_write_addr_o      = addr_reg;
  assign ram_write_data_o      = data_reg;
  assign ram_wr_en_o           = wr_en_reg;
  assign last_good_frame_idx_o = last_good_reg;
  assign frame_strobe_o        = strobe_reg;
  assign i2s_locked_o          = locked_reg;

`ifdef I2S_RX_ERR_CNT_EN
  assign err_count_o = err_cnt_reg;
`else
  logic unused_err;
  assign unused_err = ^err_cnt_reg;
`endif

endmodule

// File: tb/tb_i2s_msb_receiver.sv
// Directed bench for i2s_msb_receiver: clean frames, wrap, lrclk error, mid-frame start, mid-frame reset.
module tb_i2s_msb_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [10:0] ram_addr;
  logic        ram_data;
  logic        ram_wr_en;
  logic [2:0]  last_good;
  logic        strobe;
  logic        locked;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  i2s_msb_receiver #(.CIRC_BUF_BITS(3), .LOCK_FRAMES(2)) dut (
    .clk_x4_i              (clk),
    .rst_ni                (rst_n),
    .i2s_bclk_i            (bclk),
    .i2s_lrclk_i           (lrclk),
    .i2s_data_i            (sdata),
    .ram_write_addr_o      (ram_addr),
    .ram_write_data_o      (ram_data),
    .ram_wr_en_o           (ram_wr_en),
    .last_good_frame_idx_o (last_good),
    .frame_strobe_o        (strobe),
    .i2s_locked_o          (locked)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count_o           (err_count)
`endif
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic         ram_model [0:2047];
  int           wr_count = 0;
  int           strobe_count = 0;
  int           strobe_misalign = 0;
  logic [10:0]  first_addr = '1;
  logic [2:0]   strobe_log [0:63];
  logic [255:0] pat [0:16];

  // Passive monitor: mirrors RAM writes and logs published indices
  always @(negedge clk) begin
    if (ram_wr_en) begin
      ram_model[ram_addr] <= ram_data;
      if (wr_count == 0) first_addr <= ram_addr;
      wr_count <= wr_count + 1;
    end
    if (strobe) begin
      if (strobe_count < 64) strobe_log[strobe_count] <= last_good;
      strobe_count <= strobe_count + 1;
      if (!(ram_wr_en && ram_addr[7:0] == 8'd255)) strobe_misalign <= strobe_misalign + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [255:0] p, input int first, input int last);
    for (int b = first; b <= last; b++) send_bit(b < 128, p[b]);
  endtask

  task automatic flush();
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [255:0] slot_bits(input int s);
    logic [255:0] r;
    for (int b = 0; b < 256; b++) r[b] = ram_model[s * 256 + b];
    return r;
  endfunction

  initial begin
    int wr_before;
    for (int f = 0; f < 17; f++)
      for (int w = 0; w < 8; w++) pat[f][w*32 +: 32] = $urandom;

    repeat (5) @(negedge clk);
    check("reset_wr_en", ram_wr_en, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_last_good", last_good, 0);
    check("reset_strobe", strobe, 0);
    check("reset_locked", locked, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Stream joins mid-frame in the lrclk-low half
    for (int b = 200; b < 256; b++) send_bit(1'b0, pat[16][b]);
    flush();
    check("midframe_no_writes", wr_count, 0);

    send_bits(pat[0], 0, 255);
    flush();
    check("f0_first_addr", first_addr, 0);
    check("f0_wr_count", wr_count, 256);
    check("f0_ram_slot0", slot_bits(0), pat[0]);
    check("f0_strobe_count", strobe_count, 1);
    check("f0_last_good", last_good, 0);
    check("f0_locked", locked, 0);

    send_bits(pat[1], 0, 255);
    flush();
    check("f1_locked", locked, 1);
    check("f1_last_good", last_good, 1);

    for (int f = 2; f < 9; f++) send_bits(pat[f], 0, 255);
    flush();
    check("wrap_strobe_count", strobe_count, 9);
    for (int i = 0; i < 9; i++) check($sformatf("wrap_idx%0d", i), strobe_log[i], i % 8);
    check("strobe_on_bit255", strobe_misalign, 0);
    check("wrap_ram_slot0", slot_bits(0), pat[8]);

    // Slots 1 and 2, then lrclk falls early at bit 100 of the slot-3 frame
    send_bits(pat[9], 0, 255);
    send_bits(pat[10], 0, 255);
    flush();
    wr_before = wr_count;
    send_bits(pat[11], 0, 99);
    for (int b = 100; b < 256; b++) send_bit(1'b0, pat[11][b]);
    flush();
    check("err_writes_stop_at_100", wr_count - wr_before, 100);
    check("err_locked", locked, 0);
    check("err_last_good", last_good, 2);
    check("err_strobe_count", strobe_count, 11);
`ifdef I2S_RX_ERR_CNT_EN
    check("err_count_one", err_count, 1);
`endif
    send_bits(pat[12], 0, 255);
    flush();
    check("recover_last_good", last_good, 3);
    check("recover_locked", locked, 0);
    check("recover_ram_slot3", slot_bits(3), pat[12]);
    send_bits(pat[13], 0, 255);
    flush();
    check("recover_relock", locked, 1);
    check("recover_last_good2", last_good, 4);

    // Reset asserted at bit 50 of the slot-5 frame
    send_bits(pat[14], 0, 49);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_wr_en", ram_wr_en, 0);
    check("rst_mid_addr", ram_addr, 0);
    check("rst_mid_last_good", last_good, 0);
    check("rst_mid_locked", locked, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(pat[14], 50, 255);
    flush();
    check("rst_nothing_published", strobe_count, 13);
    check("rst_partial_locked", locked, 0);
`ifdef I2S_RX_ERR_CNT_EN
    check("rst_err_count", err_count, 1);
`endif
    send_bits(pat[15], 0, 255);
    flush();
    check("rst_f1_last_good", last_good, 0);
    check("rst_f1_locked", locked, 0);
    check("rst_f1_ram_slot0", slot_bits(0), pat[15]);
    send_bits(pat[16], 0, 255);
    flush();
    check("rst_f2_last_good", last_good, 1);
    check("rst_f2_locked", locked, 1);

`ifdef I2S_RX_ERR_CNT_EN
    // Each 1,0 pair is a frame start followed by an lrclk error
    for (int i = 0; i < 300; i++) begin
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
    end
    flush();
    check("err_count_saturated", err_count, 255);
    check("err_burst_locked", locked, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
